// File: rtl/sa_ax_channel_arbiter_pkg.sv
// Shared definitions for the slave-side Ax channel arbiter and the master dispatchers.
// Ax payload packing order (MSB to LSB) is {ID, ADDR, BURST, LEN, SIZE}.
package sa_ax_channel_arbiter_pkg;

   typedef enum logic {
      AX_IDLE,
      AX_HOLD
   } ax_state_t;

   // A single master still needs a one-bit index so the slave-side ID keeps a defined layout.
   function automatic int mst_id_width(input int mst_amt);
      return (mst_amt > 1) ? $clog2(mst_amt) : 1;
   endfunction

   function automatic int ax_payload_width(
      input int id_w,
      input int addr_w,
      input int burst_w,
      input int len_w,
      input int size_w
   );
      return id_w + addr_w + burst_w + len_w + size_w;
   endfunction

endpackage

// File: rtl/sa_ax_channel_arbiter_fifo.sv
// Small synchronous FIFO used as the grant-order queue for the slave xDATA channel.
// A push on a full FIFO is only taken when a pop frees the head in the same cycle.
module sa_ax_channel_arbiter_fifo #(
   parameter int DATA_WIDTH = 1,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1,
   parameter int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output logic                  empty,
   output logic                  full,
   output logic [CNT_W-1:0]      count
);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   // Depth need not be a power of two, so pointers wrap on an explicit compare.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == CNT_W'(FIFO_DEPTH));

endmodule

// File: rtl/sa_ax_channel_arbiter.sv
// Slave-side AW/AR arbiter: round-robin grant among master dispatchers, one registered
// output slot, and a grant-order FIFO that steers the slave xDATA channel.
module sa_ax_channel_arbiter
   import sa_ax_channel_arbiter_pkg::*;
#(
   parameter int MST_AMT           = 2,
   parameter int OUTSTANDING_AMT   = 8,
   parameter int OUTST_CTN_W       = $clog2(OUTSTANDING_AMT) + 1,
   parameter int ADDR_WIDTH        = 32,
   parameter int TRANS_MST_ID_W    = 5,
   parameter int TRANS_BURST_W     = 2,
   parameter int TRANS_DATA_LEN_W  = 3,
   parameter int TRANS_DATA_SIZE_W = 3,
   parameter int MST_ID_W          = mst_id_width(MST_AMT),
   parameter int TRANS_SLV_ID_W    = TRANS_MST_ID_W + MST_ID_W
)(
   input  logic                                  ACLK_i,
   input  logic                                  ARESETn_i,
   input  logic [TRANS_MST_ID_W*MST_AMT-1:0]     m_AxID_i,
   input  logic [ADDR_WIDTH*MST_AMT-1:0]         m_AxADDR_i,
   input  logic [TRANS_BURST_W*MST_AMT-1:0]      m_AxBURST_i,
   input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]   m_AxLEN_i,
   input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]  m_AxSIZE_i,
   input  logic [MST_AMT-1:0]                    m_AxVALID_i,
   output logic [MST_AMT-1:0]                    m_AxREADY_o,
   output logic [TRANS_SLV_ID_W-1:0]             s_AxID_o,
   output logic [ADDR_WIDTH-1:0]                 s_AxADDR_o,
   output logic [TRANS_BURST_W-1:0]              s_AxBURST_o,
   output logic [TRANS_DATA_LEN_W-1:0]           s_AxLEN_o,
   output logic [TRANS_DATA_SIZE_W-1:0]          s_AxSIZE_o,
   output logic                                  s_AxVALID_o,
   input  logic                                  s_AxREADY_i,
   input  logic                                  s_xVALID_i,
   input  logic                                  s_xREADY_i,
   input  logic                                  s_xLAST_i,
   output logic [MST_ID_W-1:0]                   dsp_xDATA_mst_id_o,
   output logic                                  dsp_xDATA_disable_o,
   output logic [OUTST_CTN_W-1:0]                outst_ctn_o
);

   localparam int PAYLOAD_W = ax_payload_width(TRANS_SLV_ID_W, ADDR_WIDTH, TRANS_BURST_W,
                                               TRANS_DATA_LEN_W, TRANS_DATA_SIZE_W);
   localparam int SIZE_LSB  = 0;
   localparam int LEN_LSB   = SIZE_LSB + TRANS_DATA_SIZE_W;
   localparam int BURST_LSB = LEN_LSB + TRANS_DATA_LEN_W;
   localparam int ADDR_LSB  = BURST_LSB + TRANS_BURST_W;
   localparam int ID_LSB    = ADDR_LSB + ADDR_WIDTH;

   logic [TRANS_MST_ID_W-1:0]    mst_id    [MST_AMT];
   logic [ADDR_WIDTH-1:0]        mst_addr  [MST_AMT];
   logic [TRANS_BURST_W-1:0]     mst_burst [MST_AMT];
   logic [TRANS_DATA_LEN_W-1:0]  mst_len   [MST_AMT];
   logic [TRANS_DATA_SIZE_W-1:0] mst_size  [MST_AMT];

   ax_state_t             state;
   ax_state_t             state_next;
   logic [MST_ID_W-1:0]   rr_ptr;
   logic [MST_ID_W-1:0]   grant_idx;
   logic                  grant_found;
   logic [MST_ID_W:0]     cand_sum;
   logic [MST_ID_W-1:0]   cand;
   logic [PAYLOAD_W-1:0]  sel_payload;
   logic [PAYLOAD_W-1:0]  payload_q;
   logic                  load_slot;
   logic                  s_hs;
   logic                  pop_req;
   logic                  push;
   logic                  pop;
   logic                  space;
   logic                  accept;
   logic                  fifo_empty;
   logic                  fifo_full;

   for (genvar k = 0; k < MST_AMT; k++) begin : g_unpack
      assign mst_id[k]    = m_AxID_i[k*TRANS_MST_ID_W +: TRANS_MST_ID_W];
      assign mst_addr[k]  = m_AxADDR_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign mst_burst[k] = m_AxBURST_i[k*TRANS_BURST_W +: TRANS_BURST_W];
      assign mst_len[k]   = m_AxLEN_i[k*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
      assign mst_size[k]  = m_AxSIZE_i[k*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
   end

   // Round-robin: first requester at or above rr_ptr, wrapping by compare so any MST_AMT works.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand_sum    = '0;
      cand        = '0;
      for (int i = 0; i < MST_AMT; i++) begin
         cand_sum = {1'b0, rr_ptr} + (MST_ID_W + 1)'(i);
         if (cand_sum >= (MST_ID_W + 1)'(MST_AMT)) begin
            cand_sum = cand_sum - (MST_ID_W + 1)'(MST_AMT);
         end
         cand = cand_sum[MST_ID_W-1:0];
         if (!grant_found && m_AxVALID_i[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   assign sel_payload = {grant_idx, mst_id[grant_idx], mst_addr[grant_idx],
                         mst_burst[grant_idx], mst_len[grant_idx], mst_size[grant_idx]};

   assign s_AxVALID_o = (state == AX_HOLD);
   assign s_hs        = s_AxVALID_o && s_AxREADY_i;
   assign push        = s_hs;
   assign pop_req     = s_xVALID_i && s_xREADY_i && s_xLAST_i;
   assign pop         = pop_req && !fifo_empty;

   // The held slot counts as outstanding: it enters the FIFO on the same edge it leaves.
   assign space  = (int'(outst_ctn_o) + int'(push) - int'(pop)) < OUTSTANDING_AMT;
   assign accept = ((state == AX_IDLE) || s_hs) && space && grant_found;

   always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
      if (!ARESETn_i) begin
         state <= AX_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      m_AxREADY_o = '0;
      load_slot   = 1'b0;
      case (state)
         AX_IDLE: begin
            if (accept) begin
               state_next = AX_HOLD;
            end
         end
         AX_HOLD: begin
            if (s_hs && !accept) begin
               state_next = AX_IDLE;
            end
         end
      endcase
      if (accept) begin
         m_AxREADY_o[grant_idx] = 1'b1;
         load_slot              = 1'b1;
      end
   end

   always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
      if (!ARESETn_i) begin
         payload_q <= '0;
         rr_ptr    <= '0;
      end else if (load_slot) begin
         payload_q <= sel_payload;
         rr_ptr    <= (grant_idx == MST_ID_W'(MST_AMT - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   assign s_AxID_o    = payload_q[ID_LSB +: TRANS_SLV_ID_W];
   assign s_AxADDR_o  = payload_q[ADDR_LSB +: ADDR_WIDTH];
   assign s_AxBURST_o = payload_q[BURST_LSB +: TRANS_BURST_W];
   assign s_AxLEN_o   = payload_q[LEN_LSB +: TRANS_DATA_LEN_W];
   assign s_AxSIZE_o  = payload_q[SIZE_LSB +: TRANS_DATA_SIZE_W];

   sa_ax_channel_arbiter_fifo #(
      .DATA_WIDTH (MST_ID_W),
      .FIFO_DEPTH (OUTSTANDING_AMT),
      .CNT_W      (OUTST_CTN_W)
   ) u_order_fifo (
      .clk       (ACLK_i),
      .rst_n     (ARESETn_i),
      .push      (push),
      .push_data (payload_q[PAYLOAD_W-1 -: MST_ID_W]),
      .pop       (pop),
      .head      (dsp_xDATA_mst_id_o),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (outst_ctn_o)
   );

   assign dsp_xDATA_disable_o = fifo_empty;

   pop_while_empty_a : assert property (@(posedge ACLK_i) disable iff (!ARESETn_i)
      !(pop_req && fifo_empty))
      else $warning("order FIFO: xLAST handshake with no outstanding burst, ignored");

   push_while_full_a : assert property (@(posedge ACLK_i) disable iff (!ARESETn_i)
      !(push && fifo_full && !pop))
      else $error("order FIFO: push on full FIFO without a pop");

endmodule

// File: tb/tb_sa_ax_channel_arbiter.sv
// Self-checking bench: a queue-based model of the grant order and slot, checked every
// negedge, plus hand-computed expectations for the reset/alternation/full/reset-in-HOLD cases.
module tb_sa_ax_channel_arbiter;

   localparam int MST_AMT = 2;
   localparam int OUT_AMT = 8;
   localparam int CTN_W   = 4;
   localparam int ADDR_W  = 32;
   localparam int ID_W    = 5;
   localparam int BURST_W = 2;
   localparam int LEN_W   = 3;
   localparam int SIZE_W  = 3;
   localparam int MID_W   = 1;
   localparam int SID_W   = 6;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [ID_W-1:0]    tb_id    [MST_AMT];
   logic [ADDR_W-1:0]  tb_addr  [MST_AMT];
   logic [BURST_W-1:0] tb_burst [MST_AMT];
   logic [LEN_W-1:0]   tb_len   [MST_AMT];
   logic [SIZE_W-1:0]  tb_size  [MST_AMT];
   logic               tb_valid [MST_AMT];

   logic [ID_W*MST_AMT-1:0]    m_AxID_i;
   logic [ADDR_W*MST_AMT-1:0]  m_AxADDR_i;
   logic [BURST_W*MST_AMT-1:0] m_AxBURST_i;
   logic [LEN_W*MST_AMT-1:0]   m_AxLEN_i;
   logic [SIZE_W*MST_AMT-1:0]  m_AxSIZE_i;
   logic [MST_AMT-1:0]         m_AxVALID_i;
   logic [MST_AMT-1:0]         m_AxREADY_o;
   logic [SID_W-1:0]           s_AxID_o;
   logic [ADDR_W-1:0]          s_AxADDR_o;
   logic [BURST_W-1:0]         s_AxBURST_o;
   logic [LEN_W-1:0]           s_AxLEN_o;
   logic [SIZE_W-1:0]          s_AxSIZE_o;
   logic                       s_AxVALID_o;
   logic                       s_AxREADY_i;
   logic                       s_xVALID_i;
   logic                       s_xREADY_i;
   logic                       s_xLAST_i;
   logic [MID_W-1:0]           dsp_xDATA_mst_id_o;
   logic                       dsp_xDATA_disable_o;
   logic [CTN_W-1:0]           outst_ctn_o;

   assign m_AxID_i    = {tb_id[1], tb_id[0]};
   assign m_AxADDR_i  = {tb_addr[1], tb_addr[0]};
   assign m_AxBURST_i = {tb_burst[1], tb_burst[0]};
   assign m_AxLEN_i   = {tb_len[1], tb_len[0]};
   assign m_AxSIZE_i  = {tb_size[1], tb_size[0]};
   assign m_AxVALID_i = {tb_valid[1], tb_valid[0]};

   sa_ax_channel_arbiter dut (
      .ACLK_i              (clk),
      .ARESETn_i           (rst_n),
      .m_AxID_i            (m_AxID_i),
      .m_AxADDR_i          (m_AxADDR_i),
      .m_AxBURST_i         (m_AxBURST_i),
      .m_AxLEN_i           (m_AxLEN_i),
      .m_AxSIZE_i          (m_AxSIZE_i),
      .m_AxVALID_i         (m_AxVALID_i),
      .m_AxREADY_o         (m_AxREADY_o),
      .s_AxID_o            (s_AxID_o),
      .s_AxADDR_o          (s_AxADDR_o),
      .s_AxBURST_o         (s_AxBURST_o),
      .s_AxLEN_o           (s_AxLEN_o),
      .s_AxSIZE_o          (s_AxSIZE_o),
      .s_AxVALID_o         (s_AxVALID_o),
      .s_AxREADY_i         (s_AxREADY_i),
      .s_xVALID_i          (s_xVALID_i),
      .s_xREADY_i          (s_xREADY_i),
      .s_xLAST_i           (s_xLAST_i),
      .dsp_xDATA_mst_id_o  (dsp_xDATA_mst_id_o),
      .dsp_xDATA_disable_o (dsp_xDATA_disable_o),
      .outst_ctn_o         (outst_ctn_o)
   );

   int checks   = 0;
   int failures = 0;

   // Model: whether a request sits in the output slot, its contents, the RR pointer,
   // and the list of granted masters whose data bursts have not yet finished.
   bit                 mdl_slot = 1'b0;
   int                 mdl_mst  = 0;
   logic [ID_W-1:0]    mdl_id;
   logic [ADDR_W-1:0]  mdl_addr;
   logic [BURST_W-1:0] mdl_burst;
   logic [LEN_W-1:0]   mdl_len;
   logic [SIZE_W-1:0]  mdl_size;
   int                 mdl_rr   = 0;
   int                 order_q[$];

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin : compare_model
      int               g;
      int               c;
      bit               s_hs;
      bit               pop;
      bit               any_valid;
      bit               accept;
      logic [MST_AMT-1:0] exp_ready;
      if (!rst_n) begin
         mdl_slot = 1'b0;
         mdl_rr   = 0;
         order_q.delete();
         checkOutput("rst_s_valid", 64'(s_AxVALID_o), 64'd0);
         checkOutput("rst_m_ready", 64'(m_AxREADY_o), 64'd0);
         checkOutput("rst_ctn", 64'(outst_ctn_o), 64'd0);
         checkOutput("rst_disable", 64'(dsp_xDATA_disable_o), 64'd1);
         checkOutput("rst_s_id", 64'(s_AxID_o), 64'd0);
         checkOutput("rst_s_addr", 64'(s_AxADDR_o), 64'd0);
      end else begin
         checkOutput("s_valid", 64'(s_AxVALID_o), 64'(mdl_slot));
         if (mdl_slot) begin
            checkOutput("s_id", 64'(s_AxID_o), 64'((mdl_mst << ID_W) | int'(mdl_id)));
            checkOutput("s_addr", 64'(s_AxADDR_o), 64'(mdl_addr));
            checkOutput("s_burst", 64'(s_AxBURST_o), 64'(mdl_burst));
            checkOutput("s_len", 64'(s_AxLEN_o), 64'(mdl_len));
            checkOutput("s_size", 64'(s_AxSIZE_o), 64'(mdl_size));
         end
         checkOutput("outst_ctn", 64'(outst_ctn_o), 64'(order_q.size()));
         checkOutput("xdata_disable", 64'(dsp_xDATA_disable_o), 64'(order_q.size() == 0));
         if (order_q.size() > 0) begin
            checkOutput("xdata_mst_id", 64'(dsp_xDATA_mst_id_o), 64'(order_q[0]));
         end
         s_hs      = mdl_slot && s_AxREADY_i;
         pop       = s_xVALID_i && s_xREADY_i && s_xLAST_i && (order_q.size() > 0);
         any_valid = tb_valid[0] || tb_valid[1];
         accept    = (!mdl_slot || s_hs) &&
                     (order_q.size() + int'(s_hs) - int'(pop) < OUT_AMT) && any_valid;
         g = -1;
         for (int k = 0; k < MST_AMT; k++) begin
            c = (mdl_rr + k) % MST_AMT;
            if (g < 0 && tb_valid[c]) g = c;
         end
         exp_ready = accept ? MST_AMT'(1 << g) : '0;
         checkOutput("m_ready", 64'(m_AxREADY_o), 64'(exp_ready));
         if (pop) void'(order_q.pop_front());
         if (s_hs) order_q.push_back(mdl_mst);
         if (accept) begin
            mdl_slot  = 1'b1;
            mdl_mst   = g;
            mdl_id    = tb_id[g];
            mdl_addr  = tb_addr[g];
            mdl_burst = tb_burst[g];
            mdl_len   = tb_len[g];
            mdl_size  = tb_size[g];
            mdl_rr    = (g + 1) % MST_AMT;
         end else if (s_hs) begin
            mdl_slot = 1'b0;
         end
      end
   end

   task automatic setPayload(input int k, input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                             input logic [BURST_W-1:0] burst, input logic [LEN_W-1:0] len,
                             input logic [SIZE_W-1:0] size);
      tb_id[k]    = id;
      tb_addr[k]  = addr;
      tb_burst[k] = burst;
      tb_len[k]   = len;
      tb_size[k]  = size;
   endtask

   // One cycle of stimulus, driven 1 ns after the rising edge; xlast_hs asks for a
   // completed last-beat handshake, otherwise the xDATA lines wiggle without one.
   task automatic applyStimulus(input logic [1:0] valid, input bit sready, input bit xlast_hs);
      logic xv;
      logic xr;
      @(posedge clk);
      #1;
      tb_valid[0] = valid[0];
      tb_valid[1] = valid[1];
      s_AxREADY_i = sready;
      if (xlast_hs) begin
         s_xVALID_i = 1'b1;
         s_xREADY_i = 1'b1;
         s_xLAST_i  = 1'b1;
      end else begin
         xv = 1'($urandom);
         xr = 1'($urandom);
         s_xVALID_i = xv;
         s_xREADY_i = xr;
         s_xLAST_i  = 1'($urandom) & ~(xv & xr);
      end
   endtask

   task automatic doReset();
      @(posedge clk);
      #3;
      rst_n       = 1'b0;
      tb_valid[0] = 1'b0;
      tb_valid[1] = 1'b0;
      s_AxREADY_i = 1'b0;
      s_xVALID_i  = 1'b0;
      s_xREADY_i  = 1'b0;
      s_xLAST_i   = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int sready_pct;
      int pop_pct;
      logic [1:0] v;
      bit hs;
      for (int k = 0; k < MST_AMT; k++) begin
         setPayload(k, '0, '0, '0, '0, '0);
         tb_valid[k] = 1'b0;
      end
      s_AxREADY_i = 1'b0;
      s_xVALID_i  = 1'b0;
      s_xREADY_i  = 1'b0;
      s_xLAST_i   = 1'b0;
      rst_n       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      $display("[TB] single request latency and ctn update");
      setPayload(0, 5'd3, 32'h4000_0010, 2'd1, 3'd2, 3'd2);
      setPayload(1, 5'd9, 32'h8000_0020, 2'd2, 3'd4, 3'd1);
      applyStimulus(2'b01, 1'b0, 1'b0);
      #1 checkOutput("t1_ready_same_cycle", 64'(m_AxREADY_o), 64'h1);
      applyStimulus(2'b00, 1'b0, 1'b0);
      #1 checkOutput("t1_s_valid", 64'(s_AxVALID_o), 64'h1);
      checkOutput("t1_s_id", 64'(s_AxID_o), 64'h03);
      checkOutput("t1_s_addr", 64'(s_AxADDR_o), 64'h4000_0010);
      checkOutput("t1_s_len", 64'(s_AxLEN_o), 64'h2);
      checkOutput("t1_ctn_before_hs", 64'(outst_ctn_o), 64'h0);
      applyStimulus(2'b00, 1'b1, 1'b0);
      #1 checkOutput("t1_ctn_during_hs", 64'(outst_ctn_o), 64'h0);
      applyStimulus(2'b00, 1'b0, 1'b0);
      #1 checkOutput("t1_ctn_after_hs", 64'(outst_ctn_o), 64'h1);
      checkOutput("t1_s_valid_idle", 64'(s_AxVALID_o), 64'h0);
      checkOutput("t1_head", 64'(dsp_xDATA_mst_id_o), 64'h0);
      applyStimulus(2'b00, 1'b0, 1'b1);
      applyStimulus(2'b00, 1'b0, 1'b0);
      #1 checkOutput("t1_ctn_after_pop", 64'(outst_ctn_o), 64'h0);

      $display("[TB] alternation and simultaneous push/pop");
      doReset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(2'b11, 1'b1, 1'b0);
         #1 checkOutput("t2_alternate", 64'(m_AxREADY_o), (i % 2 == 0) ? 64'h1 : 64'h2);
         if (i > 0) checkOutput("t2_valid_held", 64'(s_AxVALID_o), 64'h1);
      end
      applyStimulus(2'b00, 1'b1, 1'b1);
      #1 checkOutput("t4_ctn_before", 64'(outst_ctn_o), 64'h3);
      checkOutput("t4_head_before", 64'(dsp_xDATA_mst_id_o), 64'h0);
      applyStimulus(2'b00, 1'b0, 1'b0);
      #1 checkOutput("t4_ctn_after", 64'(outst_ctn_o), 64'h3);
      checkOutput("t4_head_after", 64'(dsp_xDATA_mst_id_o), 64'h1);

      $display("[TB] outstanding limit");
      doReset();
      repeat (12) applyStimulus(2'b11, 1'b1, 1'b0);
      #1 checkOutput("t3_ctn_full", 64'(outst_ctn_o), 64'h8);
      checkOutput("t3_no_ready_full", 64'(m_AxREADY_o), 64'h0);
      applyStimulus(2'b00, 1'b0, 1'b1);
      applyStimulus(2'b11, 1'b0, 1'b0);
      #1 checkOutput("t3_ctn_after_pop", 64'(outst_ctn_o), 64'h7);
      checkOutput("t3_one_grant", 64'(m_AxREADY_o), 64'h1);
      applyStimulus(2'b11, 1'b0, 1'b0);
      #1 checkOutput("t3_hold_no_grant", 64'(m_AxREADY_o), 64'h0);
      applyStimulus(2'b11, 1'b1, 1'b0);
      #1 checkOutput("t3_slot_drain_no_grant", 64'(m_AxREADY_o), 64'h0);
      applyStimulus(2'b11, 1'b0, 1'b0);
      #1 checkOutput("t3_ctn_refull", 64'(outst_ctn_o), 64'h8);

      $display("[TB] HOLD stability and reset mid-HOLD");
      doReset();
      setPayload(1, 5'd7, 32'hA5A5_0000, 2'd2, 3'd5, 3'd3);
      applyStimulus(2'b01, 1'b0, 1'b0);
      applyStimulus(2'b10, 1'b1, 1'b0);
      #1 checkOutput("t5_back_to_back", 64'(m_AxREADY_o), 64'h2);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(2'b00, 1'b0, 1'b0);
         #1 checkOutput("t5_hold_valid", 64'(s_AxVALID_o), 64'h1);
         checkOutput("t5_hold_id", 64'(s_AxID_o), 64'h27);
         checkOutput("t5_hold_addr", 64'(s_AxADDR_o), 64'hA5A5_0000);
         checkOutput("t5_hold_ctn", 64'(outst_ctn_o), 64'h1);
      end
      #1 rst_n = 1'b0;
      #1 checkOutput("t5_async_valid", 64'(s_AxVALID_o), 64'h0);
      checkOutput("t5_async_ctn", 64'(outst_ctn_o), 64'h0);
      checkOutput("t5_async_disable", 64'(dsp_xDATA_disable_o), 64'h1);
      @(posedge clk);
      #1 rst_n = 1'b1;

      $display("[TB] pop while empty");
      applyStimulus(2'b00, 1'b0, 1'b1);
      #1 checkOutput("t6_ctn_during", 64'(outst_ctn_o), 64'h0);
      applyStimulus(2'b00, 1'b0, 1'b0);
      #1 checkOutput("t6_ctn_after", 64'(outst_ctn_o), 64'h0);
      checkOutput("t6_disable", 64'(dsp_xDATA_disable_o), 64'h1);

      $display("[TB] randomized traffic");
      for (int p = 0; p < 12; p++) begin
         sready_pct = $urandom_range(20, 100);
         pop_pct    = $urandom_range(0, 60);
         for (int c = 0; c < 200; c++) begin
            for (int k = 0; k < MST_AMT; k++) begin
               setPayload(k, ID_W'($urandom), $urandom, BURST_W'($urandom),
                          LEN_W'($urandom), SIZE_W'($urandom));
            end
            v  = 2'($urandom);
            hs = (order_q.size() > 0) && ($urandom_range(0, 99) < pop_pct);
            applyStimulus(v, $urandom_range(0, 99) < sready_pct, hs);
         end
      end

      applyStimulus(2'b00, 1'b0, 1'b0);
      @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
